// File: rtl/imem_fetch_responder.sv
// Instruction-fetch responder: word-addressed instruction store with a load port,
// configurable access latency and a single outstanding request.
// Build option: define IMEM_ERR_EBREAK_EN to return ebreak on access faults.
module imem_fetch_responder #(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 1,
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [63:0]              req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_inst,
  output logic                     rsp_err,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [31:0]              prog_data
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

`ifdef IMEM_ERR_EBREAK_EN
  localparam logic [31:0] ERR_INST = 32'h0010_0073;
`else
  localparam logic [31:0] ERR_INST = 32'h0000_0000;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      addr_q;
  logic [31:0]      mem [DEPTH];
  logic [31:0]      rsp_inst_q;
  logic             rsp_err_q;
  logic             accept;
  logic             load_rsp;
  logic [63:0]      lookup_addr;
  logic [63:0]      off;
  logic [63:0]      idx_full;
  logic [IDX_W-1:0] idx;
  logic             lookup_err;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_inst  = rsp_inst_q;
  assign rsp_err   = rsp_err_q;
  assign accept    = req_valid && req_ready;

  // With LATENCY==1 the response is resolved on the accept edge, so IDLE looks up the live address.
  assign lookup_addr = (state_q == IDLE) ? req_addr : addr_q;
  assign off         = lookup_addr - BASE_ADDR;
  assign idx_full    = off >> 2;
  assign idx         = idx_full[IDX_W-1:0];
  assign lookup_err  = (lookup_addr[1:0] != 2'b00) || (lookup_addr < BASE_ADDR)
                       || (idx_full >= 64'(DEPTH));

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_rsp = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            load_rsp = 1'b1;
            state_d  = RESP;
          end else begin
            cnt_d   = CNT_W'(LATENCY - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          load_rsp = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments; that is also what makes a
    // same-edge load-port write invisible to the response read below.
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      rsp_inst_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) addr_q <= req_addr;
      if (load_rsp) begin
        rsp_inst_q <= lookup_err ? ERR_INST : mem[idx];
        rsp_err_q  <= lookup_err;
      end
    end
  end

  // NOTE: the instruction store has no reset; its contents survive rst and are set via the load port.
  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr] <= prog_data;
  end

endmodule
